// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file.
//   NUM_WRITE synchronous write ports; on an address conflict the highest-index port wins.
//   NUM_READ combinational read ports, with optional same-cycle write-to-read bypass.
//   Optional hardwired zero register, plus a sequential clear engine that wipes one entry
//   per cycle.
// Ports:
//   clk      - clock; all state updates on the rising edge
//   reset_n  - asynchronous active-low reset; loads CLEAR_VALUE into every entry
//   we/wa/wd - per-port write enable, address and data (packed, port p at slice p)
//   ra/rd    - per-port read address and read data (packed, port r at slice r)
//   clr_req  - start a clear sequence (sampled level, acted on only in idle)
//   clr_busy - clear engine active
//   clr_done - one-cycle pulse after the last entry has been cleared
module regfile_mp #(
  parameter int unsigned          DATA_WIDTH    = 64,
  parameter int unsigned          ADDRESS_WIDTH = 5,
  parameter int unsigned          REGISTER_SIZE = 2 ** ADDRESS_WIDTH,
  parameter int unsigned          NUM_READ      = 2,
  parameter int unsigned          NUM_WRITE     = 2,
  parameter bit                   ZERO_REG      = 1'b1,
  parameter bit                   BYPASS        = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NUM_WRITE-1:0]                we,
  input  logic [NUM_WRITE*ADDRESS_WIDTH-1:0]  wa,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0]     wd,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0]   ra,
  output logic [NUM_READ*DATA_WIDTH-1:0]      rd,
  input  logic                                clr_req,
  output logic                                clr_busy,
  output logic                                clr_done
);

  typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

  localparam logic [ADDRESS_WIDTH:0] LastIdx = (ADDRESS_WIDTH + 1)'(REGISTER_SIZE - 1);

  state_e                   r_state, w_state_next;
  logic [ADDRESS_WIDTH:0]   r_cnt, w_cnt_next;
  logic [DATA_WIDTH-1:0]    r_mem [REGISTER_SIZE];

  logic [ADDRESS_WIDTH-1:0] w_wa [NUM_WRITE];
  logic [DATA_WIDTH-1:0]    w_wd [NUM_WRITE];
  logic [NUM_WRITE-1:0]     w_wr_en;

  // Unpack write ports and qualify enables (zero register and out-of-range addresses).
  always_comb begin
    w_wr_en = '0;
    for (int unsigned p = 0; p < NUM_WRITE; p++) begin
      w_wa[p]    = wa[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      w_wd[p]    = wd[p*DATA_WIDTH +: DATA_WIDTH];
      w_wr_en[p] = we[p] && !(ZERO_REG && (w_wa[p] == '0)) &&
                   (32'(w_wa[p]) < REGISTER_SIZE);
    end
  end

  // Clear-engine FSM next state.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = '0;
    unique case (r_state)
      StIdle:  if (clr_req) w_state_next = StClear;
      StClear: begin
        w_cnt_next = r_cnt + 1'b1;
        if (r_cnt == LastIdx) w_state_next = StDone;
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Array update. Writes are issued in ascending port order so the highest-index port's
  // non-blocking assignment lands last and wins a conflict.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < REGISTER_SIZE; i++) r_mem[i] <= CLEAR_VALUE;
    end else if (r_state == StClear) begin
      r_mem[r_cnt[ADDRESS_WIDTH-1:0]] <= CLEAR_VALUE;
    end else begin
      for (int unsigned p = 0; p < NUM_WRITE; p++) begin
        if (w_wr_en[p]) r_mem[w_wa[p]] <= w_wd[p];
      end
    end
  end

  // Combinational reads: array, then bypass (idle only), then zero-register override.
  always_comb begin
    logic [ADDRESS_WIDTH-1:0] w_ra;
    logic [DATA_WIDTH-1:0]    w_data;
    rd = '0;
    for (int unsigned r = 0; r < NUM_READ; r++) begin
      w_ra   = ra[r*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      w_data = (32'(w_ra) < REGISTER_SIZE) ? r_mem[w_ra] : CLEAR_VALUE;
      if (BYPASS && (r_state == StIdle)) begin
        for (int unsigned p = 0; p < NUM_WRITE; p++) begin
          if (we[p] && (w_wa[p] == w_ra)) w_data = w_wd[p];
        end
      end
      if (ZERO_REG && (w_ra == '0)) w_data = '0;
      rd[r*DATA_WIDTH +: DATA_WIDTH] = w_data;
    end
  end

  assign clr_busy = (r_state == StClear);
  assign clr_done = (r_state == StDone);

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus pushes expected values into a queue right after
// each rising edge; a monitor pops and compares them on the following falling edge.
// A second instance with BYPASS=0 shares all inputs to check the no-bypass read behaviour.
module tb_regfile_mp;

  localparam int DW = 64;
  localparam int AW = 5;

  typedef struct {
    int          kind;   // 0 rd0, 1 rd1, 2 rd1 of no-bypass copy, 3 clr_busy, 4 clr_done
    logic [63:0] exp;
    string       name;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [1:0]      we;
  logic [2*AW-1:0] wa;
  logic [2*DW-1:0] wd;
  logic [2*AW-1:0] ra;
  logic            clr_req;
  logic [2*DW-1:0] rd, rd_nb;
  logic            clr_busy, clr_done, busy_nb, done_nb;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk(clk), .reset_n(reset_n), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  regfile_mp #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset_n(reset_n), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_nb),
    .clr_req(clr_req), .clr_busy(busy_nb), .clr_done(done_nb)
  );

  function automatic logic [63:0] observe(input int kind);
    case (kind)
      0:       return rd[63:0];
      1:       return rd[127:64];
      2:       return rd_nb[127:64];
      3:       return {63'b0, clr_busy};
      default: return {63'b0, clr_done};
    endcase
  endfunction

  // Monitor: compare every queued expectation on the falling edge.
  initial begin
    exp_t        e;
    logic [63:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e   = q.pop_front();
        act = observe(e.kind);
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic expect_val(input int kind, input logic [63:0] v, input string name);
    exp_t e;
    e.kind = kind;
    e.exp  = v;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[p]            = 1'b1;
    wa[p*AW +: AW]   = a;
    wd[p*DW +: DW]   = d;
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    ra[AW-1:0]    = a0;
    ra[2*AW-1:AW] = a1;
  endtask

  task automatic fill_all();
    for (int i = 0; i < 32; i++) begin
      step();
      we = '0;
      wr(0, AW'(i), 64'(i + 1));
    end
    step();
    we = '0;
  endtask

  task automatic read_all_zero(input string name);
    for (int i = 0; i < 32; i++) begin
      step();
      set_ra(AW'(i), AW'(i));
      expect_val(0, 64'h0, name);
      expect_val(2, 64'h0, name);
    end
  endtask

  // Full clear sequence with exact busy/done timing; optionally hammer addr 3 during busy.
  task automatic run_clear(input bit hammer);
    step();
    clr_req = 1'b1;
    expect_val(3, 64'd0, "busy_before_req");
    step();                        // edge N samples clr_req
    clr_req = 1'b0;
    for (int c = 0; c < 32; c++) begin
      if (hammer) begin
        wr(0, 5'd3, 64'hFF);
        set_ra(5'd3, 5'd3);
        // entry 3 is cleared at edge N+4; writes and bypass are blocked meanwhile
        expect_val(0, (c <= 3) ? 64'd4 : 64'd0, "clear_rd3");
      end
      expect_val(3, 64'd1, "busy_during_clear");
      expect_val(4, 64'd0, "done_during_clear");
      step();
    end
    we = '0;
    expect_val(3, 64'd0, "busy_in_done");
    expect_val(4, 64'd1, "done_pulse");
    step();
    expect_val(3, 64'd0, "busy_after_done");
    expect_val(4, 64'd0, "done_single");
  endtask

  initial begin
    reset_n = 1'b1;
    we      = '0;
    wa      = '0;
    wd      = '0;
    ra      = '0;
    clr_req = 1'b0;
    #1;
    reset_n = 1'b0;
    set_ra(5'd5, 5'd0);
    expect_val(0, 64'h0, "reset_rd0");
    expect_val(1, 64'h0, "reset_rd1");
    expect_val(3, 64'h0, "reset_busy");
    expect_val(4, 64'h0, "reset_done");
    step();
    step();
    reset_n = 1'b1;

    // Basic write, visible through bypass before the edge and from the array after it.
    step();
    wr(0, 5'd5, 64'h1234);
    set_ra(5'd5, 5'd5);
    expect_val(0, 64'h1234, "w5_bypass");
    expect_val(2, 64'h0, "w5_nobypass_pre");
    step();
    we = '0;
    expect_val(0, 64'h1234, "w5_read");
    expect_val(2, 64'h1234, "w5_nobypass_post");

    // Conflict: port 1 wins.
    step();
    wr(0, 5'd7, 64'hAAAA);
    wr(1, 5'd7, 64'hBBBB);
    set_ra(5'd7, 5'd7);
    expect_val(1, 64'hBBBB, "conflict_bypass");
    step();
    we = '0;
    expect_val(0, 64'hBBBB, "conflict_read");
    expect_val(2, 64'hBBBB, "conflict_nobypass");

    // Zero register.
    step();
    wr(0, 5'd0, 64'hDEAD);
    wr(1, 5'd0, 64'hDEAD);
    set_ra(5'd0, 5'd0);
    expect_val(0, 64'h0, "zero_inflight0");
    expect_val(1, 64'h0, "zero_inflight1");
    step();
    we = '0;
    expect_val(0, 64'h0, "zero_after0");
    expect_val(1, 64'h0, "zero_after1");
    expect_val(2, 64'h0, "zero_after_nb");

    // Bypass vs no bypass with addr 9 previously 0x11.
    step();
    wr(0, 5'd9, 64'h11);
    step();
    wr(0, 5'd9, 64'h55);
    set_ra(5'd9, 5'd9);
    expect_val(1, 64'h55, "bypass_on");
    expect_val(2, 64'h11, "bypass_off");
    step();
    we = '0;
    expect_val(1, 64'h55, "bypass_commit");
    expect_val(2, 64'h55, "bypass_commit_nb");

    // Clear engine.
    fill_all();
    set_ra(5'd31, 5'd31);
    step();
    expect_val(0, 64'd32, "fill_rd31");
    expect_val(2, 64'd32, "fill_rd31_nb");
    run_clear(1'b1);
    read_all_zero("clear_entry");

    // Reset mid-clear.
    fill_all();
    step();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int c = 0; c < 10; c++) begin
      expect_val(3, 64'd1, "busy_pre_abort");
      step();
    end
    reset_n = 1'b0;
    set_ra(5'd12, 5'd20);
    expect_val(3, 64'd0, "abort_busy");
    expect_val(4, 64'd0, "abort_done");
    expect_val(0, 64'd0, "abort_rd12");
    expect_val(2, 64'd0, "abort_rd20");
    step();
    reset_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      expect_val(3, 64'd0, "abort_no_busy");
      expect_val(4, 64'd0, "abort_no_done");
      step();
    end
    read_all_zero("abort_entry");
    run_clear(1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the RISC-V datapath, replacing the single-write, two-read register file. It provides NUM_READ combinational read ports and NUM_WRITE synchronous write ports with fixed write priority and a hardwired zero register. Optional same-cycle write-to-read bypass is included. A sequential clear engine wipes the array one entry per cycle on request. The block sits between decode (read addresses) and writeback (write ports).

## Interface
- DATA_WIDTH, 64, register width in bits
- ADDRESS_WIDTH, 5, register address width
- REGISTER_SIZE, 2**ADDRESS_WIDTH, number of registers
- NUM_READ, 2, read ports (1..4)
- NUM_WRITE, 2, write ports (1..2)
- ZERO_REG, 1, when 1 register 0 reads 0 and ignores writes
- BYPASS, 1, when 1 reads return same-cycle write data
- CLEAR_VALUE, 0, value loaded by reset and by the clear engine
- clk  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- we  in  NUM_WRITE  per-port write enable
- wa  in  NUM_WRITE*ADDRESS_WIDTH  write addresses, port p at [p*ADDRESS_WIDTH +: ADDRESS_WIDTH]
- wd  in  NUM_WRITE*DATA_WIDTH  write data, packed the same way
- ra  in  NUM_READ*ADDRESS_WIDTH  read addresses, packed
- rd  out  NUM_READ*DATA_WIDTH  read data, packed
- clr_req  in  1  start sequential clear (sampled level, acted on in IDLE)
- clr_busy  out  1  clear engine active
- clr_done  out  1  one-cycle pulse when the last entry has been cleared

## Operation
- Reset (reset_n low): all entries set to CLEAR_VALUE immediately. FSM goes to IDLE, clear counter resets to 0, clr_busy=0, clr_done=0. rd outputs follow the array combinationally, giving CLEAR_VALUE (or 0 for address 0 when ZERO_REG=1).
- Writes: on a rising edge in IDLE, each port with we[p]=1 writes wd[p] to wa[p].
  - Same address on several ports: the highest-index port wins.
  - Address 0 is never written when ZERO_REG=1.
- Reads are combinational: rd[r] = array[ra[r]].
  - If ZERO_REG=1 and ra[r]==0, rd[r]=0 regardless of other settings.
  - If BYPASS=1, the FSM is in IDLE, and any we[p] matches ra[r], rd[r] returns wd of the highest-index matching port.
- FSM states:
  - IDLE to CLEAR when clr_req=1. Writes in that same cycle still commit.
  - CLEAR: writes CLEAR_VALUE to entry cnt each cycle, cnt increments from 0 to REGISTER_SIZE-1. clr_busy=1. All we are ignored, bypass is disabled, and reads return the stored array contents.
  - CLEAR to DONE after the entry REGISTER_SIZE-1 write.
  - DONE: clr_done=1 and clr_busy=0 for one cycle. Writes are accepted again. Then go to IDLE.
- clr_req while in CLEAR or DONE is ignored. No queueing.
- Counter is ADDRESS_WIDTH+1 bits wide, so it does not wrap before the terminal compare.
- reset_n asserted mid-clear aborts the sequence: IDLE, all entries reset, no clr_done pulse.

## Timing
- Write latency: 1 edge. A value written at edge N is visible on rd without bypass from edge N onward. With BYPASS=1 it is visible combinationally in the cycle before edge N.
- Read latency: 0 cycles (combinational from ra, we, wa, wd).
- Clear sequence timing, with clr_req sampled at edge N:
  - clr_busy rises after edge N.
  - Entries 0..REGISTER_SIZE-1 are cleared at edges N+1..N+REGISTER_SIZE.
  - clr_done is high for the cycle after edge N+REGISTER_SIZE.
  - Total busy time is REGISTER_SIZE cycles (32 at defaults).
- No combinational path from clr_req to any output.

## Test plan
- Reset then read: reset_n low, ra={5,0}, release. Required: rd={0,0}. Write port0 addr 5 = 0x1234, then read addr 5. Required: rd[0]=0x1234 after the edge.
- Write conflict: we=2'b11, wa={7,7}, wd port0=0xAAAA, port1=0xBBBB. Required: addr 7 reads 0xBBBB afterwards.
- Zero register: write 0xDEAD to addr 0 on both ports. Required: addr 0 reads 0 before and after the edge, including while the write is in flight with BYPASS=1.
- Bypass: we[0]=1, wa=9, wd=0x55, ra[1]=9 in the same cycle, with addr 9 previously 0x11. Required: rd[1]=0x55 before the edge (BYPASS=1); rd[1]=0x11 before the edge when BYPASS=0.
- Clear engine: fill all 32 entries with their index+1, pulse clr_req, and drive we=1 to addr 3 = 0xFF during busy. Required: clr_busy high exactly 32 cycles, a single clr_done pulse, all entries = 0 afterwards, addr 3 ≠ 0xFF.
- Reset mid-clear: assert reset_n low at cycle 10 of the clear. Required: clr_busy=0 immediately, no clr_done pulse, all entries 0. A subsequent clr_req runs a full 32-cycle sequence.
